// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: 3-bit opcode encodings, FSM state
// encodings and a helper that flags the reserved opcodes.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // 100 and 101 are reserved; everything else is a real operation.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op != 3'b100) && (op != 3'b101);
  endfunction

endpackage

// File: rtl/alu_core_comb.sv
// Combinational single-cycle ALU slice: AND, OR, ADD, SUB, SLT with carry and
// signed-overflow flags. Any other opcode (MUL, reserved) yields all zeros; the
// caller handles those.
// Ports:
//   a, b  in  WIDTH  operands
//   op    in  3      opcode (alu_pkg encodings)
//   z     out WIDTH  result
//   cout  out 1      carry (ADD) or no-borrow (SUB/SLT)
//   ovf   out 1      signed overflow (ADD/SUB)
module alu_core_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0] add_full;
  logic [WIDTH:0] sub_full;
  logic           ovf_add;
  logic           ovf_sub;
  logic           lt;

  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) & (add_full[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) & (sub_full[WIDTH-1] != a[WIDTH-1]);
  // Signed less-than: sign of the difference, corrected when the subtraction overflowed.
  assign lt      = sub_full[WIDTH-1] ^ ovf_sub;

  always_comb begin
    z    = '0;
    cout = 1'b0;
    ovf  = 1'b0;
    case (op)
      OP_AND: z = a & b;
      OP_OR:  z = a | b;
      OP_ADD: begin
        z    = add_full[WIDTH-1:0];
        cout = add_full[WIDTH];
        ovf  = ovf_add;
      end
      OP_SUB: begin
        z    = sub_full[WIDTH-1:0];
        cout = sub_full[WIDTH];
        ovf  = ovf_sub;
      end
      OP_SLT: begin
        z    = {{(WIDTH-1){1'b0}}, lt};
        cout = sub_full[WIDTH];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered, valid/ready handshaked ALU. Single-cycle ops land in the output
// registers one edge after accept; MUL is an unsigned shift-add taking WIDTH
// iterations plus one load cycle.
// Ports:
//   clk, rst          clock (rising) and asynchronous active-high reset
//   in_valid/in_ready input handshake; a, b, op captured on accept
//   out_valid/out_ready output handshake; outputs held while stalled
//   z                 result
//   cout              carry (ADD), no-borrow (SUB/SLT), else 0
//   zero              z == 0
//   ovf               signed overflow (ADD/SUB), high half nonzero (MUL)
//   err               illegal opcode
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   z_q, z_d;
  logic               cout_q, cout_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   core_z;
  logic               core_cout;
  logic               core_ovf;
  logic               accept;
  logic               load;

  alu_core_comb #(
    .WIDTH (WIDTH)
  ) u_core (
    .a    (a),
    .b    (b),
    .op   (op),
    .z    (core_z),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  assign in_ready = ~rst & (state_q == S_IDLE) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    z_d         = z_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    load        = 1'b0;

    // Drain first; a result loaded on the same edge overrides it.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            load        = 1'b1;
            out_valid_d = 1'b1;
            if (op_is_legal(op)) begin
              z_d    = core_z;
              cout_d = core_cout;
              ovf_d  = core_ovf;
              err_d  = 1'b0;
            end else begin
              z_d    = '0;
              cout_d = 1'b0;
              ovf_d  = 1'b0;
              err_d  = 1'b1;
            end
          end
        end
      end
      S_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        load        = 1'b1;
        out_valid_d = 1'b1;
        z_d         = acc_q[WIDTH-1:0];
        cout_d      = 1'b0;
        ovf_d       = |acc_q[2*WIDTH-1:WIDTH];
        err_d       = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // zero only tracks z when a result is loaded, so it stays 0 out of reset.
    zero_d = load ? (z_d == '0) : zero_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule
